// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 size/sign codes and the
// LSU controller state encoding.
package riscv_pkg;

  // Load size/sign encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store size encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the pipeline request/response handshake and the data memory bus.
// The master modport is the LSU controller itself: it initiates on the memory
// side and responds on the pipeline side. The slave modport is the
// environment (pipeline stage plus memory).
interface lsu_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/lsu_align.sv
// Purely combinational size/alignment helper for the LSU: store byte strobes
// and lane replication, legality check, and load lane extraction/extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = mem_rdata[{addr[1:0], 3'b000} +: 8];
  assign lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Decode size/sign: stores produce strobes and replicated data, loads
  // produce the extended lane; unknown codes and misalignment flag illegal.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    illegal   = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          wstrb     = 4'b0001 << addr[1:0];
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_SH: begin
          wstrb     = 4'b0011 << {addr[1], 1'b0};
          wdata_rep = {2{wdata[15:0]}};
          illegal   = addr[0];
        end
        F3_SW: begin
          wstrb     = 4'b1111;
          wdata_rep = wdata;
          illegal   = |addr[1:0];
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:  rdata_ext = {{24{lane_b[7]}}, lane_b};
        F3_LBU: rdata_ext = {24'h0, lane_b};
        F3_LH: begin
          rdata_ext = {{16{lane_h[15]}}, lane_h};
          illegal   = addr[0];
        end
        F3_LHU: begin
          rdata_ext = {16'h0, lane_h};
          illegal   = addr[0];
        end
        F3_LW: begin
          rdata_ext = mem_rdata;
          illegal   = |addr[1:0];
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between EX/MEM and the data memory port. Handles one
// request at a time, drives a word-addressed memory with byte strobes and
// returns an extended load result or an error pulse.
module lsu_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [CNT_W-1:0] cnt_q;

  logic        is_idle;
  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_illegal;
  logic        timeout_hit;

  // In IDLE the aligner judges the incoming request; afterwards it works on
  // the latched copy so the memory bus stays stable while the pipeline moves.
  assign is_idle    = (state_q == IDLE);
  assign cur_we     = is_idle ? bus.req_we     : we_q;
  assign cur_funct3 = is_idle ? bus.req_funct3 : funct3_q;
  assign cur_addr   = is_idle ? bus.req_addr   : addr_q;
  assign cur_wdata  = is_idle ? bus.req_wdata  : wdata_q;

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  lsu_align u_align (
    .we        (cur_we),
    .funct3    (cur_funct3),
    .addr      (cur_addr),
    .wdata     (cur_wdata),
    .mem_rdata (bus.mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .illegal   (al_illegal)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request latch, response data/error capture and WAIT cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= 32'h0;
            err_q    <= al_illegal;
            cnt_q    <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid)   rdata_q <= al_rdata;
          else if (timeout_hit) err_q   <= 1'b1;
          else                  cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs; every output is quiet outside its state.
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_err   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'h0;
    bus.mem_wstrb  = 4'b0000;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = al_illegal ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_wdata = al_wdata;
        bus.mem_wstrb = al_wstrb;
        if (bus.mem_gnt) state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid || timeout_hit) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: table of load/store vectors with a
// response scoreboard, plus hand-written stall, timeout and reset sequences.
module tb_lsu_mem_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();
  lsu_mem_ctrl_if bus4 ();

  lsu_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  lsu_mem_ctrl #(.TIMEOUT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.master)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          gnt_dly;
    int          rv_dly;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  localparam int NV = 17;
  vec_t  vecs [NV];
  resp_t sbq [$];
  resp_t mon_e;
  vec_t  v_hand;
  int    checks = 0;
  int    errors = 0;
  int    resp_count = 0;
  int    cnt0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      resp_count++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response pending");
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("resp_rdata", bus.resp_rdata, mon_e.rdata);
        checkBit("resp_err", bus.resp_err, mon_e.err);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    logic [31:0] exp_maddr;
    int          c0;
    exp_maddr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    checkBit("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    sbq.push_back('{v.exp_rdata, v.exp_err});
    c0 = resp_count;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = ~v.we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h0F0F_0F0F;
    if (v.exp_err) begin
      checkBit("illegal_no_mem_req", bus.mem_req, 1'b0);
      checkBit("illegal_resp_latency", bus.resp_valid, 1'b1);
    end else begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        checkBit("mem_req", bus.mem_req, 1'b1);
        checkBit("mem_we", bus.mem_we, v.we);
        checkOutput("mem_addr", bus.mem_addr, exp_maddr);
        checkBit("req_ready_busy", bus.req_ready, 1'b0);
        if (v.we) begin
          checkOutput("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, v.exp_strb});
          checkOutput("mem_wdata", bus.mem_wdata, v.exp_mwdata);
        end
        if (k == v.gnt_dly) bus.mem_gnt = 1'b1;
        @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      checkBit("mem_req_drop", bus.mem_req, 1'b0);
      if (!v.we) begin
        for (int k = 0; k < v.rv_dly; k++) begin
          checkBit("req_ready_wait", bus.req_ready, 1'b0);
          checkBit("no_early_resp", bus.resp_valid, 1'b0);
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.mrdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h5A5A_5A5A;
      end
      checkBit("resp_latency", bus.resp_valid, 1'b1);
    end
    @(negedge clk);
    checkOutput("single_pulse", 32'(resp_count - c0), 32'd1);
    checkBit("resp_valid_low", bus.resp_valid, 1'b0);
    checkBit("req_ready_back", bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, F3_SW,  32'h0000_0010, 32'hDEADBEEF, 32'h0,         0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, F3_SB,  32'h0000_0013, 32'h0000_00A5, 32'h0,        0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, F3_SB,  32'h0000_0020, 32'h1234_5677, 32'h0,        0, 0, 4'b0001, 32'h77777777, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, F3_SH,  32'h0000_000A, 32'h1234_ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCDABCD, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, F3_LB,  32'h0000_0021, 32'h0,        32'h12348067,  0, 0, 4'b0000, 32'h0,        32'hFFFFFF80,  1'b0};
    vecs[5]  = '{1'b0, F3_LBU, 32'h0000_0021, 32'h0,        32'h12348067,  0, 0, 4'b0000, 32'h0,        32'h00000080,  1'b0};
    vecs[6]  = '{1'b0, F3_LH,  32'h0000_0022, 32'h0,        32'h80010000,  0, 0, 4'b0000, 32'h0,        32'hFFFF8001,  1'b0};
    vecs[7]  = '{1'b0, F3_LHU, 32'h0000_0030, 32'h0,        32'h0000F00F,  0, 0, 4'b0000, 32'h0,        32'h0000F00F,  1'b0};
    vecs[8]  = '{1'b0, F3_LHU, 32'h0000_0032, 32'h0,        32'h9ABC0000,  0, 1, 4'b0000, 32'h0,        32'h00009ABC,  1'b0};
    vecs[9]  = '{1'b0, F3_LB,  32'h0000_0003, 32'h0,        32'h7F000000,  0, 0, 4'b0000, 32'h0,        32'h0000007F,  1'b0};
    vecs[10] = '{1'b0, F3_LW,  32'h0000_0044, 32'h0,        32'hCAFEBABE,  1, 2, 4'b0000, 32'h0,        32'hCAFEBABE,  1'b0};
    vecs[11] = '{1'b0, F3_LW,  32'h0000_0006, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        32'h0,         1'b1};
    vecs[12] = '{1'b1, 3'b100, 32'h0000_0040, 32'h1111_2222, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,         1'b1};
    vecs[13] = '{1'b0, F3_LH,  32'h0000_0005, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        32'h0,         1'b1};
    vecs[14] = '{1'b0, 3'b011, 32'h0000_0008, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        32'h0,         1'b1};
    vecs[15] = '{1'b1, F3_SW,  32'h0000_0002, 32'h3333_4444, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,         1'b1};
    vecs[16] = '{1'b1, F3_SH,  32'h0000_000B, 32'h5555_6666, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,         1'b1};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_funct3 = 3'b000;
    bus4.req_addr = 32'h0; bus4.req_wdata = 32'h0;
    bus4.mem_gnt = 1'b0; bus4.mem_rvalid = 1'b0; bus4.mem_rdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    checkBit("rst_req_ready", bus.req_ready, 1'b1);
    checkBit("rst_mem_req", bus.mem_req, 1'b0);
    checkBit("rst_resp_valid", bus.resp_valid, 1'b0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);

    // Load with grant withheld 3 cycles and read data 5 cycles later
    v_hand = '{1'b0, F3_LW, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 3, 5, 4'b0000, 32'h0, 32'h0BAD_F00D, 1'b0};
    applyStimulus(v_hand);

    // Timeout on the TIMEOUT=4 instance: no read data ever arrives
    @(negedge clk);
    bus4.req_valid = 1'b1; bus4.req_we = 1'b0; bus4.req_funct3 = F3_LW;
    bus4.req_addr = 32'h0000_0060;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    checkBit("to_mem_req", bus4.mem_req, 1'b1);
    bus4.mem_gnt = 1'b1;
    @(negedge clk);
    bus4.mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkBit("to_wait_no_resp", bus4.resp_valid, 1'b0);
      @(negedge clk);
    end
    checkBit("to_resp_valid", bus4.resp_valid, 1'b1);
    checkBit("to_resp_err", bus4.resp_err, 1'b1);
    checkOutput("to_resp_rdata", bus4.resp_rdata, 32'h0);
    @(negedge clk);
    checkBit("to_pulse_end", bus4.resp_valid, 1'b0);
    checkBit("to_ready_back", bus4.req_ready, 1'b1);

    // Reset while in ISSUE drops mem_req at once
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_SW;
    bus.req_addr = 32'h0000_0200; bus.req_wdata = 32'h1234_5678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkBit("abort_issue_pre", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    checkBit("abort_issue_mem_req", bus.mem_req, 1'b0);
    checkBit("abort_issue_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while in WAIT; a late read response must be ignored
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_LW;
    bus.req_addr = 32'h0000_0050;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    checkBit("abort_wait_pre", bus.req_ready, 1'b0);
    cnt0 = resp_count;
    rst_n = 1'b0;
    #1;
    checkBit("abort_wait_mem_req", bus.mem_req, 1'b0);
    checkBit("abort_wait_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_resp", 32'(resp_count - cnt0), 32'd0);
    checkBit("abort_idle_ready", bus.req_ready, 1'b1);

    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
